// File: rtl/artec_dma_pkg.sv
// Shared types for the AXIS-to-AXI DMA: register-block settings bundle,
// frame sequencer state encoding and write-descriptor layout.
`timescale 1ns/1ps
package artec_dma_pkg;
  localparam int PKG_CH_NUM     = 6;
  localparam int PKG_FB_NUM     = 8;
  localparam int PKG_STATUS_CH  = PKG_CH_NUM;
  localparam int PKG_STATUS_LEN = 4;

  typedef struct packed {
    logic        enable;
    logic [31:0] offset;
    logic [31:0] channel_size;
  } channel_t;

  typedef struct packed {
    logic                         start;
    logic                         stop;
    logic                         clear;
    logic [PKG_FB_NUM-1:0][31:0]  framebuffer_addr;
    logic [31:0]                  status_addr;
    channel_t [PKG_CH_NUM-1:0]    channel;
  } settings_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_ISSUE,
    ST_WAIT,
    ST_STS_ISSUE,
    ST_STS_WAIT
  } frame_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] len;
    logic [2:0]  ch;
    logic [31:0] data;
  } desc_t;
endpackage

// File: rtl/artec_dma_ch_pick.sv
// Combinational finder: lowest channel index >= start_i that is enabled and
// has a non-zero transfer size.
`timescale 1ns/1ps
module artec_dma_ch_pick
  import artec_dma_pkg::*;
#(
  parameter int CH_NUM = PKG_CH_NUM,
  parameter int IDX_W  = 3
) (
  input  logic [CH_NUM-1:0] en_i,
  input  logic [CH_NUM-1:0] nz_i,
  input  logic [IDX_W-1:0]  start_i,
  output logic              found_o,
  output logic [IDX_W-1:0]  idx_o
);
  // Scan from the top so the lowest qualifying index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (en_i[i] && nz_i[i] && (IDX_W'(i) >= start_i)) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/artec_dma_frame_ctrl.sv
// Frame sequencer: walks frame buffers round-robin issuing one write descriptor per
// enabled channel. Per-frame status write is built when ARTEC_DMA_FRAME_STATUS_EN is defined.
`timescale 1ns/1ps
module artec_dma_frame_ctrl
  import artec_dma_pkg::*;
#(
  parameter int CH_NUM = PKG_CH_NUM,
  parameter int FB_NUM = PKG_FB_NUM
) (
  input  logic        clk,
  input  logic        rstn,
  input  settings_t   settings_i,
  output logic        desc_valid_o,
  input  logic        desc_ready_i,
  output logic [31:0] desc_addr_o,
  output logic [31:0] desc_len_o,
  output logic [2:0]  desc_ch_o,
  output logic [31:0] desc_data_o,
  input  logic        done_i,
  input  logic        done_err_i,
  output logic        stop_o,
  output logic [31:0] frame_status_o,
  output logic [31:0] frame_number_o
);
  localparam int CHW = $clog2(CH_NUM + 1);
  localparam int FBW = (FB_NUM > 1) ? $clog2(FB_NUM) : 1;

  frame_state_e   state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [FBW-1:0] fb_q, fb_d, fb_next;
  logic           err_q, err_d;
  logic           stop_pend_q, stop_pend_d;
  logic [31:0]    frame_num_q, frame_num_d;
  desc_t          desc_q, desc_d;
  logic           frame_done;

  logic [CH_NUM-1:0] en_mask, nz_mask;
  logic [CHW-1:0]    pick_start, pick_idx;
  logic              pick_found;
  logic [31:0]       sel_off, sel_size, sel_fb;

  // In WAIT the finder looks one past the current channel, so the last done_i
  // of a frame can be recognised without another trip through PICK.
  assign pick_start = (state_q == ST_WAIT) ? ch_q + CHW'(1) : ch_q;
  assign fb_next    = (fb_q == FBW'(FB_NUM - 1)) ? '0 : fb_q + FBW'(1);

  artec_dma_ch_pick #(.CH_NUM(CH_NUM), .IDX_W(CHW)) u_pick (
    .en_i    (en_mask),
    .nz_i    (nz_mask),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    en_mask  = '0;
    nz_mask  = '0;
    sel_off  = '0;
    sel_size = '0;
    sel_fb   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      en_mask[i] = settings_i.channel[i].enable;
      nz_mask[i] = |settings_i.channel[i].channel_size;
      if (pick_idx == CHW'(i)) begin
        sel_off  = settings_i.channel[i].offset;
        sel_size = settings_i.channel[i].channel_size;
      end
    end
    for (int j = 0; j < FB_NUM; j++) begin
      if (fb_q == FBW'(j)) sel_fb = settings_i.framebuffer_addr[j];
    end
  end

`ifndef ARTEC_DMA_FRAME_STATUS_EN
  logic unused_status_addr;
  assign unused_status_addr = ^settings_i.status_addr;
`endif

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    fb_d        = fb_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;
    frame_num_d = frame_num_q;
    desc_d      = desc_q;
    frame_done  = 1'b0;
    if (state_q != ST_IDLE && settings_i.stop) stop_pend_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (settings_i.start) begin
          ch_d        = '0;
          fb_d        = '0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = ST_PICK;
        end
      end
      ST_PICK: begin
        if (pick_found) begin
          desc_d.addr = sel_fb + sel_off;
          desc_d.len  = sel_size;
          desc_d.ch   = 3'(pick_idx);
          desc_d.data = '0;
          ch_d        = pick_idx;
          state_d     = ST_ISSUE;
        end else begin
`ifdef ARTEC_DMA_FRAME_STATUS_EN
          desc_d.addr = settings_i.status_addr;
          desc_d.len  = 32'(PKG_STATUS_LEN);
          desc_d.ch   = 3'(CH_NUM);
          desc_d.data = {err_q, 15'b0, 8'(fb_q), frame_num_q[7:0]};
          state_d     = ST_STS_ISSUE;
`else
          frame_done  = 1'b1;
`endif
        end
      end
      ST_ISSUE: if (desc_ready_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_i) begin
          err_d = err_q | done_err_i;
          ch_d  = ch_q + CHW'(1);
`ifdef ARTEC_DMA_FRAME_STATUS_EN
          state_d = ST_PICK;
`else
          if (pick_found) state_d = ST_PICK;
          else            frame_done = 1'b1;
`endif
        end
      end
`ifdef ARTEC_DMA_FRAME_STATUS_EN
      ST_STS_ISSUE: if (desc_ready_i) state_d = ST_STS_WAIT;
      ST_STS_WAIT:  if (done_i) frame_done = 1'b1;
`endif
      default: state_d = ST_IDLE;
    endcase
    if (frame_done) begin
      frame_num_d = frame_num_q + 32'd1;
      fb_d        = fb_next;
      ch_d        = '0;
      state_d     = (stop_pend_q || settings_i.stop) ? ST_IDLE : ST_PICK;
    end
    // clear overrides everything, including a descriptor still waiting for ready.
    if (settings_i.clear) begin
      state_d     = ST_IDLE;
      ch_d        = '0;
      fb_d        = '0;
      err_d       = 1'b0;
      stop_pend_d = 1'b0;
      frame_num_d = '0;
      desc_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      fb_q        <= '0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      frame_num_q <= '0;
      desc_q      <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      fb_q        <= fb_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      frame_num_q <= frame_num_d;
      desc_q      <= desc_d;
    end
  end

  assign desc_valid_o   = ((state_q == ST_ISSUE) || (state_q == ST_STS_ISSUE)) && !settings_i.clear;
  assign desc_addr_o    = desc_q.addr;
  assign desc_len_o     = desc_q.len;
  assign desc_ch_o      = desc_q.ch;
  assign desc_data_o    = desc_q.data;
  assign stop_o         = (state_q == ST_IDLE);
  assign frame_status_o = {err_q, (state_q != ST_IDLE), 22'b0, 8'(fb_q)};
  assign frame_number_o = frame_num_q;
endmodule

// File: doc/artec_dma_frame_ctrl.md
# artec_dma_frame_ctrl

Frame sequencer for the AXIS-to-AXI DMA. Sits directly downstream of the APB register block: consumes its `settings_t` bundle and returns the `stop`, `frame_status` and `frame_number` fields of `status_t`. After `start` it walks the frame buffers round-robin. For each buffer it issues one write descriptor per enabled channel to the AXI write engine, waits for completion, then writes a status word to `status_addr`. When it returns to idle, the register block's clear handshake is allowed to proceed.

## Interface
Parameters:
- `CH_NUM`, default `PKG_CH_NUM` (6): number of channels.
- `FB_NUM`, default `PKG_FB_NUM` (8): number of frame buffers.

Ports:
- `clk`  in  1: single clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `settings_i`  in  `settings_t`: start/stop/clear pulses, `framebuffer_addr[FB_NUM]`, `status_addr`, `channel[i].{enable,offset,channel_size}`.
- `desc_valid_o`  out  1: descriptor valid.
- `desc_ready_i`  in  1: engine accepts the descriptor.
- `desc_addr_o`  out  32: write start byte address.
- `desc_len_o`  out  32: byte length (4 for a status write).
- `desc_ch_o`  out  3: channel index; `CH_NUM` marks a status write.
- `desc_data_o`  out  32: status payload. Meaningful only when `desc_ch_o == CH_NUM`.
- `done_i`  in  1: one-cycle pulse when the outstanding descriptor completes.
- `done_err_i`  in  1: qualifies `done_i`; the write ended with an error response.
- `stop_o`  out  1: level, high while the FSM is IDLE.
- `frame_status_o`  out  32: [31] `err`, [30] `busy`, [7:0] index of the current buffer.
- `frame_number_o`  out  32: count of completed frames.

## Operation
FSM states are IDLE, PICK, ISSUE, WAIT, STS_ISSUE, STS_WAIT.
- IDLE: on a `start` pulse, set `ch=0` and `fb=0`, clear `err` and `stop_pending`, go to PICK. Ignore `stop` while in IDLE.
- PICK: a combinational finder selects the lowest channel `>= ch` with `enable=1` and `channel_size != 0`.
  - If one exists, latch it and go to ISSUE.
  - Otherwise go to STS_ISSUE.
- ISSUE: assert `desc_valid_o`. Address is `framebuffer_addr[fb] + offset[ch]` (32-bit add, wraps modulo 2^32). Length is `channel_size`. On `desc_ready_i`, go to WAIT.
- WAIT: on `done_i`, set `ch = ch+1` and OR `done_err_i` into `err`. Go to PICK; when `ch` reaches `CH_NUM`, PICK falls through to status.
- STS_ISSUE: descriptor with `addr=status_addr`, `len=4`, `ch=CH_NUM`, `data={err, 15'b0, fb[7:0], frame_number[7:0]}`. On ready, go to STS_WAIT.
- STS_WAIT: on `done_i`:
  - increment `frame_number`;
  - set `fb = (fb==FB_NUM-1) ? 0 : fb+1` and `ch=0`;
  - go to IDLE if `stop_pending`, else to PICK.
- A `stop` pulse in any non-IDLE state sets `stop_pending`. The current frame always completes, including its status write.
- A frame with all channels disabled or zero-size still performs the status write and still counts.
- `start` outside IDLE is ignored. If `start` and `stop` arrive in the same IDLE cycle, `start` wins and `stop` is dropped.
- `clear` pulse, in any state: synchronously return every register to its reset value and drop `desc_valid_o` in the same cycle. This is the only permitted exception to hold-until-ready. The register block asserts `clear` only while `stop_o=1`, but the block must tolerate it anywhere.
- Settings are sampled live. The descriptor fields are registered at the PICK→ISSUE transition and held stable while valid.

## Timing
- Reset values: `desc_valid_o=0`, all `desc_*` outputs 0, `stop_o=1`, `frame_status_o=0`, `frame_number_o=0`, state IDLE.
- Latency from `start` (cycle N) to the first `desc_valid_o`: cycle N+2 (IDLE→PICK→ISSUE).
- From `done_i` in WAIT to the next `desc_valid_o`: 2 cycles.
- Valid/ready: once asserted, valid and all fields stay stable until the handshake cycle. Valid drops in the cycle after acceptance.
- `done_i` outside WAIT/STS_WAIT is ignored.
- `stop_o` rises in the cycle after the final STS_WAIT `done_i`.
- `frame_number_o` wraps from 2^32-1 to 0.

## Configuration
- `ARTEC_DMA_FRAME_STATUS_EN` defined: STS_ISSUE and STS_WAIT exist as described.
- Not defined: both states are removed. A frame completes on the last channel's `done_i`, which performs the `frame_number`/`fb` update and the IDLE/PICK decision directly. `desc_ch_o` never equals `CH_NUM`, and `desc_data_o` is tied to 0.

## Structure
- `artec_dma_pkg` gains:
  - `frame_state_e` (FSM enum);
  - `desc_t` (`addr`, `len`, `ch`, `data`);
  - `PKG_STATUS_CH = PKG_CH_NUM`;
  - `PKG_STATUS_LEN = 4`.
- One sub-module, `artec_dma_ch_pick`: combinational next-enabled-channel finder. Inputs are the enable mask, size-nonzero mask and start index; outputs are `found` and `idx`.

## Test plan
- Channels 0 and 2 enabled, sizes 0x100/0x40, offsets 0/0x1000, `fb0=0x8000_0000` → descriptors (0x8000_0000, 0x100, ch0), (0x8000_1000, 0x40, ch2), then the status write (`status_addr`, 4, ch6, data 0x0000_0000). `frame_number_o=1`.
- Run 9 frames with `FB_NUM=8` → the 9th frame uses `fb=0` again; `frame_number_o=9`.
- Stop pulse while in WAIT of frame 3 → frame 3 still completes with its status write, then `stop_o=1` and no further descriptors.
- Hold `desc_ready_i=0` for 10 cycles with a random stall pattern → valid and fields stay constant throughout; exactly one descriptor accepted.
- `done_err_i=1` on ch1 → `frame_status_o[31]=1` and status data bit 31 set. The next `start` clears it.
- `clear` pulse during ISSUE → next cycle `desc_valid_o=0`, `stop_o=1`, `frame_number_o=0`, all outputs at reset values.
